result_printer: RTL

Converts an unsigned binary result into decimal ASCII and streams it, most significant digit first, followed by an optional end-of-line byte, into the byte-wide transmit interface of the UART transmitter. It sits between the puzzle core's result output and `uart_tx`. It is the producer side of the `en`/`busy` transmit handshake and owns all formatting, so solver cores only have to present a number.

---
 rtl/printer_pkg.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 54 +++++
 rtl/result_printer.sv | 98 +++++++++
 3 files changed

// File: rtl/printer_pkg.sv
// Shared types and constants for the decimal result printer.
// Holds the FSM state encoding, ASCII constants and the BCD capacity check.
package printer_pkg;

    typedef enum logic [2:0] {IDLE, CONV, SCAN, EMIT, GAP} state_t;

    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_LF         = 8'h0A;

    // ceil(bits * log10(2)) in integer arithmetic
    function automatic int min_digits(input int bits);
        return (bits * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one input bit per cycle, MSB first.
// done is high during the cycle whose clock edge performs the final shift.
module bin_to_bcd_seq
    import printer_pkg::*;
#(
    parameter int VALUE_BITS = 64,
    parameter int DIGITS     = 20
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [VALUE_BITS-1:0]   value,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd
);

    localparam int CNT_W = $clog2(VALUE_BITS + 1);

    logic [VALUE_BITS-1:0] shreg;
    logic [CNT_W-1:0]      cnt;
    logic [4*DIGITS-1:0]   adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign done = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            shreg <= value;
            bcd   <= '0;
            cnt   <= CNT_W'(VALUE_BITS);
            busy  <= 1'b1;
        end else if (busy) begin
            bcd   <= {adj[4*DIGITS-2:0], shreg[VALUE_BITS-1]};
            shreg <= shreg << 1;
            cnt   <= cnt - 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/result_printer.sv
// Prints an unsigned binary value as decimal ASCII (leading zeros suppressed),
// optionally followed by an end-of-line byte, over an en/busy byte interface.
module result_printer
    import printer_pkg::*;
#(
    parameter int          VALUE_BITS = 64,
    parameter int          DIGITS     = 20,
    parameter bit          EOL_EN     = 1'b1,
    parameter logic [7:0]  EOL_CHAR   = 8'h0A
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [VALUE_BITS-1:0]  value_data,
    input  logic                   value_valid,
    output logic                   value_ready,
    output logic [7:0]             out_data,
    output logic                   out_en,
    input  logic                   out_busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (DIGITS < min_digits(VALUE_BITS)) begin : g_digits_check
            $error("result_printer: DIGITS too small for VALUE_BITS");
        end
    endgenerate

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic                eol_phase;
    logic [4*DIGITS-1:0] bcd;
    logic                conv_busy;
    logic                conv_done;
    logic                accept;
    logic [3:0]          digit;

    assign value_ready = (state == IDLE) && !conv_busy;
    assign accept      = value_valid && value_ready;
    assign digit       = bcd[idx*4 +: 4];

    bin_to_bcd_seq #(
        .VALUE_BITS (VALUE_BITS),
        .DIGITS     (DIGITS)
    ) u_conv (
        .clk    (clk),
        .resetn (resetn),
        .start  (accept),
        .value  (value_data),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (bcd)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            eol_phase <= 1'b0;
            out_en    <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            out_en <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state     <= CONV;
                    eol_phase <= 1'b0;
                end
                CONV: if (conv_done) begin
                    state <= SCAN;
                    idx   <= IDX_W'(DIGITS - 1);
                end
                // Digit 0 is never skipped so a zero value still prints "0"
                SCAN: if (digit == 4'd0 && idx != '0)
                    idx <= idx - 1'b1;
                else
                    state <= EMIT;
                EMIT: if (!out_busy) begin
                    out_en   <= 1'b1;
                    out_data <= eol_phase ? EOL_CHAR : ASCII_DIGIT_BASE + {4'd0, digit};
                    state    <= GAP;
                end
                // Idle cycle lets the transmitter's busy flag rise before we look again
                GAP: if (!eol_phase && idx != '0) begin
                    idx   <= idx - 1'b1;
                    state <= EMIT;
                end else if (EOL_EN && !eol_phase) begin
                    eol_phase <= 1'b1;
                    state     <= EMIT;
                end else begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
